spi_byte_master: RTL and testbench

//  Z80-facing SPI master serving the SD card and MP3 (VS10xx) control/data channels. Consumes the
//  1-cycle start strobe plus byte from the port decoder and shifts it out MSB-first, SPI mode 0.

---
 rtl/spi_byte_master_pkg.sv | 15 +
 rtl/spi_byte_master_if.sv | 30 +++
 rtl/spi_byte_master_tick_gen.sv | 28 ++
 rtl/spi_byte_master.sv | 147 ++++++++++++++
 tb/tb_spi_byte_master.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_byte_master_pkg.sv
// Shared definitions for the byte-wide SPI master channels (SD, MC, MD).
//   spi_state_e   : transfer FSM states
//   SPI_NBITS     : default bits per transfer
//   SPI_MOSI_IDLE : default mosi level between transfers
package neogs_spi_pkg;

  typedef enum logic {
    StIdle,
    StXfer
  } spi_state_e;

  localparam int unsigned SPI_NBITS     = 8;
  localparam logic        SPI_MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_byte_master_if.sv
// CPU-side strobe/data plus SPI pins of one SPI master channel.
//   start/din/halfspeed : transfer request from the port decoder
//   dout/busy/done      : result and status back to the port decoder
//   sck/mosi/miso       : SPI mode 0 pins
// Modports: master = the SPI master block, slave = its environment.
interface spi_byte_master_if
  import neogs_spi_pkg::*;
#(
  parameter int unsigned NBITS = SPI_NBITS
);
  logic             start;
  logic [NBITS-1:0] din;
  logic             halfspeed;
  logic [NBITS-1:0] dout;
  logic             busy;
  logic             done;
  logic             sck;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, din, halfspeed, miso,
    output dout, busy, done, sck, mosi
  );

  modport slave (
    output start, din, halfspeed, miso,
    input  dout, busy, done, sck, mosi
  );
endinterface

// File: rtl/spi_byte_master_tick_gen.sv
// Half-period tick generator for spi_byte_master.
//   cpu_clock : sole clock
//   rst       : synchronous active-high reset
//   i_clear   : restart the prescaler (transfer launch)
//   i_half    : latched halfspeed; 0 = tick every cycle, 1 = every 2nd cycle
//   o_tick    : one SCK half-period has elapsed this cycle
module spi_tick_gen (
  input  logic cpu_clock,
  input  logic rst,
  input  logic i_clear,
  input  logic i_half,
  output logic o_tick
);

  logic r_pre;

  always_ff @(posedge cpu_clock) begin
    if (rst || i_clear) begin
      r_pre <= 1'b0;
    end else begin
      r_pre <= ~r_pre;
    end
  end

  // After a clear the first half-speed tick lands on the second cycle.
  assign o_tick = ~i_half | r_pre;

endmodule

// File: rtl/spi_byte_master.sv
// Z80-facing SPI master, one instance per channel (SD, MC, MD).
// Shifts din out MSB-first in SPI mode 0 while shifting a byte in from miso;
// the received byte appears on dout together with a one-cycle done pulse.
//   cpu_clock : sole clock
//   rst       : synchronous active-high reset
//   bus       : spi_byte_master_if.master (start/din/halfspeed in, dout/busy/done out,
//               sck/mosi out, miso in)
// Optional build macro SPI_START_QUEUE_EN: one-deep pending buffer for a start
// arriving while busy; launched the cycle after done. Without it such starts are dropped.
module spi_byte_master
  import neogs_spi_pkg::*;
#(
  parameter int unsigned NBITS     = SPI_NBITS,
  parameter logic        MOSI_IDLE = SPI_MOSI_IDLE
) (
  input logic              cpu_clock,
  input logic              rst,
  spi_byte_master_if.master bus
);

  localparam int unsigned CntW = (NBITS > 1) ? $clog2(NBITS) : 1;

  spi_state_e       r_state;
  logic [CntW-1:0]  r_bit_cnt;
  logic [NBITS-1:0] r_tx;
  logic [NBITS-1:0] r_rx;
  logic [NBITS-1:0] r_dout;
  logic             r_sck;
  logic             r_mosi;
  logic             r_busy;
  logic             r_done;
  logic             r_half;

  logic             w_tick;
  logic             w_last;
  logic             w_launch;
  logic [NBITS-1:0] w_launch_din;
  logic             w_launch_half;
  logic             w_hold_busy;

`ifdef SPI_START_QUEUE_EN
  logic             r_pend_vld;
  logic [NBITS-1:0] r_pend_din;
  logic             r_pend_half;
`endif

  spi_tick_gen u_tick_gen (
    .cpu_clock (cpu_clock),
    .rst       (rst),
    .i_clear   (w_launch),
    .i_half    (r_half),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_last = (r_bit_cnt == CntW'(NBITS - 1));
`ifdef SPI_START_QUEUE_EN
    // A pending request takes priority; a start seen now is then queued behind it.
    w_launch      = (r_state == StIdle) && (r_pend_vld || bus.start);
    w_launch_din  = r_pend_vld ? r_pend_din  : bus.din;
    w_launch_half = r_pend_vld ? r_pend_half : bus.halfspeed;
    // Keep busy through the done cycle if another transfer is already lined up.
    w_hold_busy   = r_pend_vld || bus.start;
`else
    w_launch      = (r_state == StIdle) && bus.start;
    w_launch_din  = bus.din;
    w_launch_half = bus.halfspeed;
    w_hold_busy   = 1'b0;
`endif
  end

  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_dout    <= '1;
      r_sck     <= 1'b0;
      r_mosi    <= MOSI_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_half    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_state   <= StXfer;
        r_busy    <= 1'b1;
        r_sck     <= 1'b0;
        r_bit_cnt <= '0;
        r_mosi    <= w_launch_din[NBITS-1];
        r_tx      <= w_launch_din << 1;
        r_half    <= w_launch_half;
      end else if ((r_state == StXfer) && w_tick) begin
        if (!r_sck) begin
          // Rising edge: sample miso.
          r_sck <= 1'b1;
          r_rx  <= (r_rx << 1) | NBITS'(bus.miso);
        end else begin
          // Falling edge: advance mosi, or finish after the last bit.
          r_sck <= 1'b0;
          if (w_last) begin
            r_state <= StIdle;
            r_dout  <= r_rx;
            r_done  <= 1'b1;
            r_mosi  <= MOSI_IDLE;
            r_busy  <= w_hold_busy;
          end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
            r_mosi    <= r_tx[NBITS-1];
            r_tx      <= r_tx << 1;
          end
        end
      end
    end
  end

`ifdef SPI_START_QUEUE_EN
  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_din  <= '0;
      r_pend_half <= 1'b0;
    end else if (r_state == StXfer) begin
      if (bus.start) begin
        r_pend_vld  <= 1'b1;
        r_pend_din  <= bus.din;
        r_pend_half <= bus.halfspeed;
      end
    end else if (r_pend_vld) begin
      // Pending request launches now; a start in this cycle refills the buffer.
      r_pend_vld <= bus.start;
      if (bus.start) begin
        r_pend_din  <= bus.din;
        r_pend_half <= bus.halfspeed;
      end
    end
  end
`endif

  assign bus.dout = r_dout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sck  = r_sck;
  assign bus.mosi = r_mosi;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master (NBITS=8).
// A transaction-level timeline model predicts every output each cycle; directed
// scenarios add literal expectations. Honours SPI_START_QUEUE_EN when defined.
module tb_spi_byte_master;

  localparam int NB = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  spi_byte_master_if #(.NBITS(NB)) bus ();

  spi_byte_master #(.NBITS(NB), .MOSI_IDLE(1'b1)) dut (
    .cpu_clock (clk),
    .rst       (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  logic [NB-1:0] next_rx;
  bit            m_valid;
  bit            m_active;
  int            m_L;
  int            m_P;
  logic [NB-1:0] m_din;
  logic [NB-1:0] m_rx;
  logic [NB-1:0] m_dout;
  bit            m_pvld;
  logic [NB-1:0] m_pdin;
  bit            m_phalf;

  // monitor
  logic          prev_sck;
  int            sck_rises;
  logic [NB-1:0] mosi_cap;
  int            done_cnt;
  int            done_cyc;

  task automatic launch(input logic [NB-1:0] d, input bit h);
    m_active = 1'b1;
    m_L      = cyc;
    m_P      = h ? 4 : 2;
    m_din    = d;
    m_rx     = next_rx;
  endtask

  always @(negedge clk) begin
    int   t, k, ph;
    logic e_busy, e_done, e_sck, e_mosi;
    logic [NB-1:0] e_dout;
    logic drv_miso;
    t        = cyc - m_L;
    drv_miso = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_sck = 1'b0; e_mosi = 1'b1; e_dout = m_dout;
    if (m_active && t >= 1 && t <= m_P * NB) begin
      k      = (t - 1) / m_P;
      ph     = (t - 1) % m_P;
      e_busy = 1'b1;
      e_sck  = (ph >= m_P / 2);
      e_mosi = m_din[NB-1-k];
      // Correct bit only while sck is low before the rising edge.
      drv_miso = (ph < m_P / 2) ? m_rx[NB-1-k] : ~m_rx[NB-1-k];
    end else if (m_active && t == m_P * NB + 1) begin
      e_busy = m_pvld;
      e_done = 1'b1;
      e_dout = m_rx;
    end
    bus.miso = drv_miso;

    if (m_valid) begin
      check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      check("done", {31'd0, bus.done}, {31'd0, e_done});
      check("sck",  {31'd0, bus.sck},  {31'd0, e_sck});
      check("mosi", {31'd0, bus.mosi}, {31'd0, e_mosi});
      check("dout", {24'd0, bus.dout}, {24'd0, e_dout});
      if (bus.sck && !prev_sck) begin
        sck_rises++;
        mosi_cap = {mosi_cap[NB-2:0], bus.mosi};
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_sck = bus.sck;

    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_pvld   = 1'b0;
      m_dout   = '1;
    end else begin
      if (m_active && t == m_P * NB + 1) begin
        m_dout   = m_rx;
        m_active = 1'b0;
        if (m_pvld) begin
          launch(m_pdin, m_phalf);
          m_pvld = 1'b0;
        end
      end
      if (bus.start) begin
        if (!m_active) begin
          launch(bus.din, bus.halfspeed);
        end else begin
`ifdef SPI_START_QUEUE_EN
          m_pvld  = 1'b1;
          m_pdin  = bus.din;
          m_phalf = bus.halfspeed;
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_mon();
    sck_rises = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    mosi_cap  = '0;
  endtask

  // Returns in cycle N+1; n is the cycle start was high.
  task automatic do_start(input logic [NB-1:0] d, input bit h, input logic [NB-1:0] rx,
                          output int n);
    next_rx       = rx;
    bus.din       = d;
    bus.halfspeed = h;
    bus.start     = 1'b1;
    n             = cyc;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    errors = 0; checks = 0;
    m_valid = 1'b0; m_active = 1'b0; m_pvld = 1'b0; m_dout = '1; m_L = 0; m_P = 2;
    prev_sck = 1'b0;
    next_rx = '0;
    clear_mon();
    rst = 1'b1;
    bus.start = 1'b0; bus.din = '0; bus.halfspeed = 1'b0; bus.miso = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_sck",  {31'd0, bus.sck},  32'd0);
    check("reset_mosi", {31'd0, bus.mosi}, 32'd1);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_dout", {24'd0, bus.dout}, 32'hFF);

    // Full speed A5 out, 3C in
    @(posedge clk); #1;
    clear_mon();
    do_start(8'hA5, 1'b0, 8'h3C, n);
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("full_done_ofs", done_cyc - n, 32'd17);
    check("full_done_cnt", done_cnt, 32'd1);
    check("full_pulses",   sck_rises, 32'd8);
    check("full_mosi_seq", {24'd0, mosi_cap}, 32'hA5);
    check("full_dout",     {24'd0, bus.dout}, 32'h3C);
    check("model_dout",    {24'd0, m_dout}, 32'h3C);

    // Half speed FF out, 00 in
    @(posedge clk); #1;
    clear_mon();
    do_start(8'hFF, 1'b1, 8'h00, n);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("half_done_ofs", done_cyc - n, 32'd33);
    check("half_pulses",   sck_rises, 32'd8);
    check("half_mosi_seq", {24'd0, mosi_cap}, 32'hFF);
    check("half_dout",     {24'd0, bus.dout}, 32'h00);

    // Back-to-back: restart the cycle after done
    @(posedge clk); #1;
    clear_mon();
    do_start(8'h5A, 1'b0, 8'hC3, n);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    check("b2b_first_done_seen", {31'd0, seen}, 32'd1);
    check("b2b_first_dout", {24'd0, bus.dout}, 32'hC3);
    @(posedge clk); #1;
    do_start(8'h81, 1'b0, 8'h7E, n);
    check("b2b_held_dout", {24'd0, bus.dout}, 32'hC3);
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("b2b_second_dout", {24'd0, bus.dout}, 32'h7E);
    check("b2b_done_cnt",    done_cnt, 32'd2);

    // Start while busy at N+5
    @(posedge clk); #1;
    clear_mon();
    do_start(8'h11, 1'b0, 8'hE7, n);
    repeat (4) @(posedge clk);
    #1;
    next_rx = 8'h42;
    bus.din = 8'h22; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
`ifdef SPI_START_QUEUE_EN
    check("busy_start_pulses", sck_rises, 32'd16);
    check("busy_start_dones",  done_cnt, 32'd2);
    check("busy_start_dout",   {24'd0, bus.dout}, 32'h42);
`else
    check("busy_start_pulses", sck_rises, 32'd8);
    check("busy_start_dones",  done_cnt, 32'd1);
    check("busy_start_dout",   {24'd0, bus.dout}, 32'hE7);
`endif

    // Reset asserted at N+8
    @(posedge clk); #1;
    clear_mon();
    do_start(8'h0F, 1'b0, 8'h55, n);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sck",  {31'd0, bus.sck},  32'd0);
    check("rst_mosi", {31'd0, bus.mosi}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_dout", {24'd0, bus.dout}, 32'hFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_no_done", done_cnt, 32'd0);

    // halfspeed toggled mid-transfer
    @(posedge clk); #1;
    clear_mon();
    do_start(8'h3C, 1'b0, 8'h96, n);
    repeat (3) @(posedge clk);
    #1 bus.halfspeed = 1'b1;
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("hs_toggle_done_ofs", done_cyc - n, 32'd17);
    check("hs_toggle_pulses",   sck_rises, 32'd8);
    check("hs_toggle_dout",     {24'd0, bus.dout}, 32'h96);
    bus.halfspeed = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
